// File: rtl/mux_lane_arbiter_pkg.sv
// mux_lane_arbiter_pkg
// Shared definitions for the lane arbiter: lane geometry, FSM state
// encoding, and the round-robin priority pick used by the arbiter.
package mux_lane_arbiter_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_W     = 2;
    localparam int CNT_W      = 8;
    localparam int LANE_IDX_W = 2;
    localparam int SEL_W      = 3;
    localparam int DATA_W     = NUM_LANES * LANE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                  found;
        logic [LANE_IDX_W-1:0] lane;
    } rr_pick_t;

    // First eligible lane found when searching upward (mod NUM_LANES) from
    // ptr. The loop runs from the farthest offset down so the nearest
    // eligible lane is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(
        input logic [NUM_LANES-1:0]  elig,
        input logic [LANE_IDX_W-1:0] ptr
    );
        rr_pick_t              res;
        logic [LANE_IDX_W-1:0] idx;
        res.found = 1'b0;
        res.lane  = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = ptr + LANE_IDX_W'(i);
            if (elig[idx]) begin
                res.found = 1'b1;
                res.lane  = idx;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_onehot(
        input logic [LANE_IDX_W-1:0] lane
    );
        return NUM_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/mux_lane_arbiter_lane_select.sv
// lane_select
// Combinational slice selector: returns the LANE_W-bit slice of data_in
// belonging to the given lane index.
//   data_in   : packed lanes, lane i at [LANE_W*i +: LANE_W]
//   lane      : lane index to extract
//   lane_data : selected slice
module lane_select
    import mux_lane_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]     data_in,
    input  logic [LANE_IDX_W-1:0] lane,
    output logic [LANE_W-1:0]     lane_data
);

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane == LANE_IDX_W'(i)) begin
                lane_data = data_in[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/mux_lane_arbiter.sv
// mux_lane_arbiter
// Round-robin scheduler sharing one 2-bit output channel among four lanes.
// Captures the winning lane's slice into a registered output held under a
// valid/ready handshake, pulses a one-cycle ack to the served lane, and
// counts completed transfers.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-lane request level
//   lane_mask  : per-lane enable, masked lanes never win
//   data_in    : packed lane payloads
//   sel        : {1'b0, lane} of the current grant
//   data_out   : registered payload of the granted lane
//   out_valid  : data_out holds an unconsumed transfer
//   out_ready  : downstream accept
//   ack        : one-hot, one-cycle pulse after a lane's transfer is accepted
//   xfer_cnt   : completed transfers, wraps silently
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | nothing held, arbitrate every cycle
// BUSY  | transfer held in data_out, out_valid high
module mux_lane_arbiter
    import mux_lane_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] req,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic [DATA_W-1:0]    data_in,
    output logic [SEL_W-1:0]     sel,
    output logic [LANE_W-1:0]    data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_LANES-1:0] ack,
    output logic [CNT_W-1:0]     xfer_cnt
);

    state_t                state_q,  state_d;
    logic [LANE_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [LANE_IDX_W-1:0] grant_q,  grant_d;
    logic [LANE_W-1:0]     data_q,   data_d;
    logic [NUM_LANES-1:0]  ack_q,    ack_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    logic                  accept;
    logic [NUM_LANES-1:0]  excl;
    logic [NUM_LANES-1:0]  elig;
    logic [LANE_IDX_W-1:0] search_ptr;
    rr_pick_t              pick;
    logic [LANE_W-1:0]     pick_data;

    // On an accept the search already uses the advanced pointer and skips
    // the lane just served; its req is still high until it sees ack, so
    // without the exclusion it would be granted a duplicate transfer.
    assign accept     = (state_q == ST_BUSY) && out_ready;
    assign excl       = accept ? lane_onehot(grant_q) : '0;
    assign search_ptr = accept ? grant_q + LANE_IDX_W'(1) : rr_ptr_q;
    assign elig       = req & lane_mask & ~excl;
    assign pick       = rr_pick(elig, search_ptr);

    lane_select u_lane_select (
        .data_in   (data_in),
        .lane      (pick.lane),
        .lane_data (pick_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ack_d    = '0;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d = ST_BUSY;
                    grant_d = pick.lane;
                    data_d  = pick_data;
                end
            end
            ST_BUSY: begin
                if (out_ready) begin
                    ack_d    = lane_onehot(grant_q);
                    cnt_d    = cnt_q + CNT_W'(1);
                    rr_ptr_d = search_ptr;
                    if (pick.found) begin
                        grant_d = pick.lane;
                        data_d  = pick_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel       = {1'b0, grant_q};
    assign data_out  = data_q;
    assign out_valid = (state_q == ST_BUSY);
    assign ack       = ack_q;
    assign xfer_cnt  = cnt_q;

endmodule
